fsub_issue_queue: RTL and testbench
===================================

Name: fsub_issue_queue

Overview:
- Issue and result-collection stage wrapped around the fixed-latency pipelined fsub unit (NSTAGE register stages, no stall input).
- Accepts tagged operand pairs over a valid/ready handshake and flushes denormal/special encodings before issue.
- Tracks in-flight operations alongside fsub and captures each fsub y/ovf with its tag into a result FIFO drained by a valid/ready consumer.
- Uses credit-based admission so fsub results can never be dropped.

Parameters:
NSTAGE, 2, fsub latency in clock edges from operand register update to result sampling
DEPTH, 4, result FIFO entries (power of two, >= 2)
TAGW, 4, tag width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  request can be accepted this cycle
in_x1  in  32  minuend, IEEE single
in_x2  in  32  subtrahend, IEEE single
in_tag  in  TAGW  request tag
fsub_x1  out  32  operand 1 to fsub, registered
fsub_x2  out  32  operand 2 to fsub, registered
fsub_y  in  32  fsub result
fsub_ovf  in  1  fsub overflow flag
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_y  out  32  head result
out_ovf  out  1  head overflow flag
out_tag  out  TAGW  head tag
out_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge):
  - fsub_x1 and fsub_x2 go to 0.
  - All in-flight valid bits clear.
  - FIFO pointers and out_count go to 0; out_valid=0.
  - in_ready=0 while rst is high, and 1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight and queued results. Any fsub output in progress is ignored because its valid bits are clear.
- Accept: on an edge where in_valid & in_ready, the block registers:
  - fsub_x1 <= flush(in_x1), fsub_x2 <= flush(in_x2);
  - stage-0 valid=1, and stage-0 tag=in_tag.
  - Otherwise fsub_x1/fsub_x2 hold their previous values and stage-0 valid=0.
- flush(x): if x[30:23] is 0x00 or 0xFF, the result is {x[31:23],23'b0}; otherwise x is passed unchanged. NaN therefore becomes ±Inf, and denormals become ±0.
- In-flight tracker: a valid+tag shift register of NSTAGE entries, advancing every edge unconditionally.
- Capture: on the edge NSTAGE edges after the accept edge, {fsub_y, fsub_ovf, tag} is written to the FIFO tail. out_valid is first high in the cycle following that edge.
- Accept-to-out_valid latency is exactly NSTAGE cycles when the FIFO is empty.
- Throughput is one operation per cycle when out_ready is held at 1.
- inflight = number of set valid bits in the tracker, counting stage 0 through the capture stage.
- Admission rule: in_ready = (out_count + inflight) < DEPTH, computed from registered state only.
  - A pop in the same cycle does not raise in_ready; this is intentionally conservative and causes one bubble.
  - in_ready does not depend on in_valid.
- Pop: on an edge where out_valid & out_ready, the head advances.
- Simultaneous capture and pop: out_count is unchanged and both pointers advance. This is legal when out_count is DEPTH; the credit rule guarantees capture never occurs into a full FIFO unless a pop happens on the same edge.
- Pointers wrap modulo DEPTH.
- Results leave in strict issue order.
- out_y, out_ovf and out_tag are only meaningful while out_valid=1. They come directly from FIFO storage, with no combinational path from fsub_y.
- fsub_ovf is passed through unmodified.

Test Plan:
- Basic: in_x1=0x40400000 (3.0), in_x2=0x3F800000 (1.0), tag=5 -> out_valid after NSTAGE cycles, out_y=0x40000000, out_ovf=0, out_tag=5.
- Flush: in_x1=0x00400001, in_x2=0x7FC00000 -> fsub_x1=0x00000000 and fsub_x2=0x7F800000 on the cycle after accept; out_y=0xFF800000.
- Overflow passthrough: in_x1=0x7F7FFFFF, in_x2=0xFF7FFFFF -> out_y=0x7F800000, out_ovf=1.
- Backpressure: DEPTH=4, out_ready=0, six back-to-back requests with tags 0..5 -> exactly tags 0..3 accepted, in_ready=0 thereafter, out_count=4, no FIFO overwrite. Raising out_ready drains tags 0,1,2,3 in order; tags 4,5 are then accepted and emerge in order.
- Streaming: out_ready=1, 100 random normal pairs issued every cycle the block is ready -> every out_y matches the reference subtraction of the flushed operands, tags are in order, and no request is lost or duplicated.
- Reset mid-flight: three requests accepted, rst asserted for one edge one cycle later -> out_valid=0, out_count=0, fsub_x1=fsub_x2=0, no stale result appears within the next NSTAGE+2 cycles, and in_ready=1 the cycle after reset.

Source files
------------

// File: rtl/fsub_issue_queue.sv
// Issue and result-collection stage around a fixed-latency pipelined fsub unit.
// Requests are flushed (denormal -> +/-0, NaN/Inf -> +/-Inf), registered onto the
// fsub operand ports, tracked alongside the fsub pipeline, and the fsub results
// are captured with their tags into a small result FIFO. Admission is credit
// based (queued + in flight < DEPTH), so a result arriving from fsub always has
// a free FIFO slot.
module fsub_issue_queue #(
    parameter int NSTAGE = 2,
    parameter int DEPTH  = 4,
    parameter int TAGW   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_x1,
    input  logic [31:0]                in_x2,
    input  logic [TAGW-1:0]            in_tag,
    output logic [31:0]                fsub_x1,
    output logic [31:0]                fsub_x2,
    input  logic [31:0]                fsub_y,
    input  logic                       fsub_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_y,
    output logic                       out_ovf,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(DEPTH+1)-1:0] out_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + NSTAGE + 1);
    localparam int EW = 33 + TAGW;

    // Exponent all-zeros or all-ones: keep sign and exponent, clear mantissa.
    function automatic logic [31:0] flush(input logic [31:0] x);
        logic [31:0] r;
        r = x;
        if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) begin
            r = {x[31:23], 23'b0};
        end
        return r;
    endfunction

    logic [31:0]     x1_q, x2_q;
    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [TAGW-1:0] tag_q [NSTAGE];
    logic [TAGW-1:0] tag_d [NSTAGE];

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic            accept;
    logic            capture;
    logic            pop;
    logic [SW-1:0]   inflight;
    logic [SW-1:0]   credits_used;
    logic [EW-1:0]   head;

    assign accept  = in_valid & in_ready;
    assign capture = vld_q[NSTAGE-1];
    assign pop     = out_valid & out_ready;

    // Count tracker entries still owed a FIFO slot (stage 0 .. capture stage).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            inflight = inflight + SW'(vld_q[i]);
        end
    end

    // Credits come only from registered state, so a same-cycle pop never
    // re-opens admission; that costs one bubble but keeps in_ready short-pathed.
    assign credits_used = SW'(count_q) + inflight;
    assign in_ready     = ~rst & (credits_used < SW'(DEPTH));

    // Operand registers feeding fsub; hold their value when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
        end else if (accept) begin
            x1_q <= flush(in_x1);
            x2_q <= flush(in_x2);
        end
    end

    assign fsub_x1 = x1_q;
    assign fsub_x2 = x2_q;

    // Tracker next state: stage 0 takes the accept, later stages shift along.
    assign vld_d[0] = accept;
    assign tag_d[0] = in_tag;
    for (genvar gi = 1; gi < NSTAGE; gi++) begin : g_stage
        assign vld_d[gi] = vld_q[gi-1];
        assign tag_d[gi] = tag_q[gi-1];
    end

    // Tracker valid bits advance every edge; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Tracker tags need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    // Result storage: capture writes the fsub output and its tag at the tail.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= {fsub_ovf, fsub_y, tag_q[NSTAGE-1]};
        end
    end

    // Occupancy next state; capture together with pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({capture, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (capture) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_count = count_q;
    assign out_ovf   = head[EW-1];
    assign out_y     = head[EW-2 -: 32];
    assign out_tag   = head[TAGW-1:0];

endmodule

// File: tb/tb_fsub_issue_queue.sv
// Bench for fsub_issue_queue: models the external fsub pipeline, drives directed
// and random requests, and checks the drained results through a scoreboard.
module tb_fsub_issue_queue;

    localparam int NSTAGE = 2;
    localparam int DEPTH  = 4;
    localparam int TAGW   = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_x1, in_x2;
    logic [TAGW-1:0] in_tag;
    logic [31:0]     fsub_x1, fsub_x2;
    logic [31:0]     fsub_y;
    logic            fsub_ovf;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_y;
    logic            out_ovf;
    logic [TAGW-1:0] out_tag;
    logic [CW-1:0]   out_count;

    typedef struct {
        logic [31:0]     y;
        logic            ovf;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fsub_issue_queue #(.NSTAGE(NSTAGE), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .fsub_x1   (fsub_x1),
        .fsub_x2   (fsub_x2),
        .fsub_y    (fsub_y),
        .fsub_ovf  (fsub_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag),
        .out_count (out_count)
    );

    // Single to double for flushed operands (zero, inf, or normal).
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h00)      d = {x[31], 63'b0};
        else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, 52'b0};
        else                        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // Reference single subtraction {ovf, y}; exact in double for the ranges used.
    function automatic logic [32:0] fsub_ref(input logic [31:0] a, input logic [31:0] b);
        real         rd;
        logic [63:0] d;
        int          e;
        logic [24:0] mant;
        rd = sp2real(a) - sp2real(b);
        d  = $realtobits(rd);
        if (rd == 0.0) return 33'h0;
        if (d[62:52] == 11'h7FF) return {1'b0, d[63], 8'hFF, 23'b0};
        e    = int'(d[62:52]) - 1023 + 127;
        mant = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'b0};
        return {1'b0, d[63], e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] flush_ref(input logic [31:0] x);
        if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) return {x[31:23], 23'b0};
        return x;
    endfunction

    // Stand-in for the fsub unit: NSTAGE-1 internal registers after the operand regs.
    logic [32:0] fpipe [NSTAGE-1];
    always @(posedge clk) begin
        fpipe[0] <= fsub_ref(fsub_x1, fsub_x2);
        for (int i = 1; i < NSTAGE - 1; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fsub_y   = fpipe[NSTAGE-2][31:0];
    assign fsub_ovf = fpipe[NSTAGE-2][32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every handshaken output is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output actual_tag=%0d y=0x%08h required=none", out_tag, out_y);
            end else begin
                e = exp_q.pop_front();
                $display("txn tag=%0d y=0x%08h ovf=%0d", out_tag, out_y, out_ovf);
                check("out_y",   out_y, e.y);
                check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                check("out_tag", 32'(out_tag), 32'(e.tag));
            end
        end
    end

    // Present one request until accepted (bounded), recording its expected result.
    task automatic send(input logic [31:0] x1, input logic [31:0] x2, input logic [TAGW-1:0] tag,
                        input logic [31:0] ey, input logic eo);
        int waited = 0;
        in_valid = 1'b1;
        in_x1    = x1;
        in_x2    = x2;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout tag=%0d actual_ready=0 required=1", tag);
        end else begin
            exp_q.push_back('{ey, eo, tag});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_count != '0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] bp_x2 [6] = '{32'h00000000, 32'h3F800000, 32'h40000000,
                               32'h40400000, 32'h40800000, 32'h40A00000};
    logic [31:0] bp_y  [6] = '{32'h40A00000, 32'h40800000, 32'h40400000,
                               32'h40000000, 32'h3F800000, 32'h00000000};

    initial begin
        logic [31:0] a, b;
        logic [32:0] r;

        rst = 1'b1; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready",     32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_count",     32'(out_count), 32'd0);
        check("reset_fsub_x1",   fsub_x1, 32'h0);
        check("reset_fsub_x2",   fsub_x2, 32'h0);
        @(posedge clk); #1;

        // Basic 3.0 - 1.0 with latency check.
        out_ready = 1'b1;
        send(32'h40400000, 32'h3F800000, 4'd5, 32'h40000000, 1'b0);
        for (int i = 0; i < NSTAGE; i++) begin
            @(negedge clk);
            check("latency_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // Flush: denormal -> +0, NaN -> +Inf, result -Inf.
        @(posedge clk); #1;
        send(32'h00400001, 32'h7FC00000, 4'd6, 32'hFF800000, 1'b0);
        @(negedge clk);
        check("flush_x1", fsub_x1, 32'h00000000);
        check("flush_x2", fsub_x2, 32'h7F800000);
        wait_drain();

        // Overflow passthrough: max - (-max).
        @(posedge clk); #1;
        send(32'h7F7FFFFF, 32'hFF7FFFFF, 4'd7, 32'h7F800000, 1'b1);
        wait_drain();

        // Backpressure: only DEPTH requests admitted while the consumer stalls.
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 6; t++) send(32'h40A00000, bp_x2[t], 4'(t), bp_y[t], 1'b0);
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_ready_blocked", 32'(in_ready), 32'd0);
                check("bp_count_full",    32'(out_count), 32'd4);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Streaming random normal pairs.
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
            r = fsub_ref(flush_ref(a), flush_ref(b));
            send(a, b, 4'(i), r[31:0], r[32]);
        end
        wait_drain();

        // Reset with work in flight and queued.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h40400000, 32'h3F800000, 4'd1, 32'h40000000, 1'b0);
        send(32'h40800000, 32'h3F800000, 4'd2, 32'h40400000, 1'b0);
        send(32'h40A00000, 32'h3F800000, 4'd3, 32'h40800000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count",     32'(out_count), 32'd0);
        check("midrst_fsub_x1",   fsub_x1, 32'h0);
        check("midrst_fsub_x2",   fsub_x2, 32'h0);
        check("midrst_in_ready",  32'(in_ready), 32'd1);
        for (int i = 0; i < NSTAGE + 2; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
